// File: rtl/alu_disp_pkg.sv
// Shared types and constants for the shared ALU / 7-segment display controllers.
package alu_disp_pkg;

  // Operand and op-select widths of the ALU datapath this block feeds.
  localparam int OPND_W      = 4;
  localparam int SEL_W       = 3;

  // Number of implemented ALU operations; selects at or above this are rejected.
  localparam int NUM_OPS_DEF = 4;

  // Controller state: waiting for a request, showing a result, forced blank.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHOW  = 2'd1,
    ST_BLANK = 2'd2
  } disp_state_e;

  // True when an op select names an implemented ALU operation.
  function automatic logic sel_is_valid(input logic [SEL_W-1:0] sel, input int num_ops);
    return (int'(sel) < num_ops);
  endfunction

  // One-hot request/ack vector for a 1-bit requester index.
  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/alu_display_arbiter_rr_arbiter2.sv
// Two-way round-robin pick. Purely combinational so any shared-display
// controller can reuse it with its own last-owner register.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic       grant_valid,
  output logic       owner
);

  // A lone request wins outright; on a tie the requester that was not
  // served last wins, which gives strict alternation under contention.
  always_comb begin
    grant_valid = |req;
    owner       = last_owner;
    case (req)
      2'b01:   owner = 1'b0;
      2'b10:   owner = 1'b1;
      2'b11:   owner = ~last_owner;
      default: owner = last_owner;
    endcase
  end

endmodule

// File: rtl/alu_display_arbiter.sv
// Shares one ALU-to-7-segment datapath between the board switches
// (requester 0) and the host interface (requester 1). The winner's operands
// are shown for a fixed dwell, followed by a forced blank before the next
// grant so the two users' results never run into each other on the display.
//
// Handshake: req[i] is a level held by requester i until it sees ack[i].
// ack[i] is a one-cycle pulse in the cycle after req was sampled in IDLE;
// a requester dropping req before ack is simply not served. err pulses
// together with ack if the granted op select names no implemented ALU
// operation (nothing is displayed in that case).
// done[i] pulses in the first cycle after requester i's dwell ends.
module alu_display_arbiter
  import alu_disp_pkg::*;
#(
  parameter int DWELL_CYCLES = 8,
  parameter int BLANK_CYCLES = 2,
  parameter int NUM_OPS      = NUM_OPS_DEF,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [3:0] op_a_0,
  input  logic [3:0] op_a_1,
  input  logic [3:0] op_b_0,
  input  logic [3:0] op_b_1,
  input  logic [2:0] op_sel_0,
  input  logic [2:0] op_sel_1,
  input  logic       pause,
  output logic [1:0] ack,
  output logic       err,
  output logic [1:0] done,
  output logic       busy,
  output logic [3:0] alu_in_1,
  output logic [3:0] alu_in_2,
  output logic [2:0] alu_sel,
  output logic       alu_en
);

  // Counter reload values: the counter runs N-1 down to 0, i.e. N cycles.
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = '0;
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  disp_state_e      state;
  logic [CNT_W-1:0] cnt;
  logic             last_owner;

  logic             grant_valid;
  logic             grant_owner;
  logic [3:0]       win_a;
  logic [3:0]       win_b;
  logic [2:0]       win_sel;
  logic             win_sel_ok;

  rr_arbiter2 u_rr (
    .req         (req),
    .last_owner  (last_owner),
    .grant_valid (grant_valid),
    .owner       (grant_owner)
  );

  // Steer the winning requester's operands toward the capture registers.
  always_comb begin
    win_a      = grant_owner ? op_a_1   : op_a_0;
    win_b      = grant_owner ? op_b_1   : op_b_0;
    win_sel    = grant_owner ? op_sel_1 : op_sel_0;
    win_sel_ok = sel_is_valid(win_sel, NUM_OPS);
  end

  // Controller FSM: arbitration in IDLE, dwell countdown in SHOW (frozen by
  // pause), blank countdown in BLANK. Every output is a register here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= CNT_ZERO;
      last_owner <= 1'b1;
      ack        <= 2'b00;
      err        <= 1'b0;
      done       <= 2'b00;
      busy       <= 1'b0;
      alu_in_1   <= 4'd0;
      alu_in_2   <= 4'd0;
      alu_sel    <= 3'd0;
      alu_en     <= 1'b0;
    end else begin
      ack  <= 2'b00;
      err  <= 1'b0;
      done <= 2'b00;
      case (state)
        ST_IDLE: begin
          if (grant_valid) begin
            // last_owner moves even on a rejected op so the other side wins
            // the next tie.
            last_owner <= grant_owner;
            ack        <= onehot2(grant_owner);
            if (win_sel_ok) begin
              alu_in_1 <= win_a;
              alu_in_2 <= win_b;
              alu_sel  <= win_sel;
              alu_en   <= 1'b1;
              busy     <= 1'b1;
              cnt      <= DWELL_LAST;
              state    <= ST_SHOW;
            end else begin
              err <= 1'b1;
            end
          end
        end

        ST_SHOW: begin
          if (!pause) begin
            if (cnt == CNT_ZERO) begin
              done   <= onehot2(last_owner);
              alu_en <= 1'b0;
              cnt    <= BLANK_LAST;
              state  <= ST_BLANK;
            end else begin
              cnt <= cnt - CNT_ONE;
            end
          end
        end

        ST_BLANK: begin
          if (cnt == CNT_ZERO) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end

        default: begin
          alu_en <= 1'b0;
          busy   <= 1'b0;
          cnt    <= CNT_ZERO;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_display_arbiter.sv
// Directed bench for alu_display_arbiter with default parameters
// (dwell 8, blank 2, 4 ops). Each expected grant is queued when stimulus is
// issued; an independent monitor pops one entry per observed ack.
module tb_alu_display_arbiter;

  logic       clk;
  logic       rst;
  logic [1:0] req;
  logic [3:0] op_a_0, op_a_1, op_b_0, op_b_1;
  logic [2:0] op_sel_0, op_sel_1;
  logic       pause;
  logic [1:0] ack;
  logic       err;
  logic [1:0] done;
  logic       busy;
  logic [3:0] alu_in_1, alu_in_2;
  logic [2:0] alu_sel;
  logic       alu_en;

  int n_vec  = 0;
  int n_fail = 0;

  // Record: {ack, err, alu_en, alu_in_1, alu_in_2, alu_sel, dwell, done}
  localparam int W = 25;
  logic [W-1:0] exp_q[$];

  alu_display_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .op_a_0   (op_a_0),
    .op_a_1   (op_a_1),
    .op_b_0   (op_b_0),
    .op_b_1   (op_b_1),
    .op_sel_0 (op_sel_0),
    .op_sel_1 (op_sel_1),
    .pause    (pause),
    .ack      (ack),
    .err      (err),
    .done     (done),
    .busy     (busy),
    .alu_in_1 (alu_in_1),
    .alu_in_2 (alu_in_2),
    .alu_sel  (alu_sel),
    .alu_en   (alu_en)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] rec(input logic [1:0] a, input logic e, input logic en,
                                       input logic [3:0] x, input logic [3:0] y,
                                       input logic [2:0] s, input logic [7:0] d,
                                       input logic [1:0] dn);
    return {a, e, en, x, y, s, d, dn};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Driver helpers (all sampling on the falling edge)
  task automatic wait_ack();
    int n;
    n = 0;
    @(negedge clk);
    while (ack === 2'b00 && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (ack === 2'b00) check("ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic count_idle(output int n);
    n = 0;
    while (busy === 1'b0 && n < 50) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_alu_en"},   32'(alu_en),   32'd0);
    check({tag, "_busy"},     32'(busy),     32'd0);
    check({tag, "_ack"},      32'(ack),      32'd0);
    check({tag, "_err"},      32'(err),      32'd0);
    check({tag, "_done"},     32'(done),     32'd0);
    check({tag, "_alu_in_1"}, 32'(alu_in_1), 32'd0);
    check({tag, "_alu_in_2"}, 32'(alu_in_2), 32'd0);
    check({tag, "_alu_sel"},  32'(alu_sel),  32'd0);
  endtask

  // Monitor: on each ack, capture the grant, measure how long alu_en stays
  // high, sample done when it falls, and compare against the queue head.
  initial begin : monitor
    logic [W-1:0] obs;
    logic [W-1:0] expv;
    logic [1:0]   c_ack;
    logic         c_err, c_en;
    logic [3:0]   c_a, c_b;
    logic [2:0]   c_s;
    int           dwell;
    forever begin
      @(negedge clk);
      if (ack !== 2'b00) begin
        c_ack = ack; c_err = err; c_en = alu_en;
        c_a = alu_in_1; c_b = alu_in_2; c_s = alu_sel;
        dwell = 0;
        while (alu_en === 1'b1 && dwell < 200) begin
          dwell++;
          @(negedge clk);
        end
        obs = rec(c_ack, c_err, c_en, c_a, c_b, c_s, 8'(dwell), done);
        if (exp_q.size() == 0) begin
          check("txn_unexpected", 32'(obs), 32'd0);
        end else begin
          expv = exp_q.pop_front();
          check("txn", 32'(obs), 32'(expv));
        end
      end
    end
  end

  // Stimulus
  initial begin : stim
    int n;
    rst = 1'b1; req = 2'b00; pause = 1'b0;
    op_a_0 = 4'd0; op_b_0 = 4'd0; op_sel_0 = 3'd0;
    op_a_1 = 4'd0; op_b_1 = 4'd0; op_sel_1 = 3'd0;

    // Reset state
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Tie straight after reset: requester 0 first, then requester 1
    op_a_0 = 4'd10; op_b_0 = 4'd8; op_sel_0 = 3'd2;
    op_a_1 = 4'd12; op_b_1 = 4'd1; op_sel_1 = 3'd1;
    exp_q.push_back(rec(2'b01, 1'b0, 1'b1, 4'd10, 4'd8, 3'd2, 8'd8, 2'b01));
    exp_q.push_back(rec(2'b10, 1'b0, 1'b1, 4'd12, 4'd1, 3'd1, 8'd8, 2'b10));
    req = 2'b11;
    wait_ack();
    req = 2'b10;
    count_busy(n);
    check("tie_busy_len_0", 32'(n), 32'd10);
    count_idle(n);
    check("tie_gap", 32'(n), 32'd1);
    req = 2'b00;
    count_busy(n);
    check("tie_busy_len_1", 32'(n), 32'd10);

    // Single request from the switches
    op_a_0 = 4'd7; op_b_0 = 4'd5; op_sel_0 = 3'd0;
    exp_q.push_back(rec(2'b01, 1'b0, 1'b1, 4'd7, 4'd5, 3'd0, 8'd8, 2'b01));
    req = 2'b01;
    wait_ack();
    req = 2'b00;
    count_busy(n);
    check("single_busy_len", 32'(n), 32'd10);

    // Invalid op from the host: err with ack, display untouched
    op_a_1 = 4'd3; op_b_1 = 4'd4; op_sel_1 = 3'd5;
    exp_q.push_back(rec(2'b10, 1'b1, 1'b0, 4'd7, 4'd5, 3'd0, 8'd0, 2'b00));
    req = 2'b10;
    wait_ack();
    check("inv_busy", 32'(busy), 32'd0);
    req = 2'b00;
    @(negedge clk);
    check("inv_err_pulse", 32'(err), 32'd0);
    check("inv_ack_pulse", 32'(ack), 32'd0);
    check("inv_busy_after", 32'(busy), 32'd0);

    // Contention held for four grants: 0,1,0,1 with one idle cycle between
    op_a_0 = 4'd1; op_b_0 = 4'd2; op_sel_0 = 3'd3;
    op_a_1 = 4'd4; op_b_1 = 4'd5; op_sel_1 = 3'd1;
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0)
        exp_q.push_back(rec(2'b01, 1'b0, 1'b1, 4'd1, 4'd2, 3'd3, 8'd8, 2'b01));
      else
        exp_q.push_back(rec(2'b10, 1'b0, 1'b1, 4'd4, 4'd5, 3'd1, 8'd8, 2'b10));
    end
    req = 2'b11;
    wait_ack();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) req = 2'b00;
      count_busy(n);
      check("rr_busy_len", 32'(n), 32'd10);
      if (i < 3) begin
        count_idle(n);
        check("rr_gap", 32'(n), 32'd1);
      end
    end

    // Pause for three cycles mid-dwell: 11 cycles shown, 13 busy
    op_a_0 = 4'd9; op_b_0 = 4'd6; op_sel_0 = 3'd1;
    exp_q.push_back(rec(2'b01, 1'b0, 1'b1, 4'd9, 4'd6, 3'd1, 8'd11, 2'b01));
    req = 2'b01;
    wait_ack();
    req = 2'b00;
    fork
      begin
        repeat (2) @(negedge clk);
        pause = 1'b1;
        repeat (3) @(negedge clk);
        pause = 1'b0;
      end
      begin
        count_busy(n);
      end
    join
    check("pause_busy_len", 32'(n), 32'd13);

    // Reset in the 4th SHOW cycle: no done, everything back to zero
    op_a_0 = 4'd2;  op_b_0 = 4'd3;  op_sel_0 = 3'd1;
    op_a_1 = 4'd11; op_b_1 = 4'd13; op_sel_1 = 3'd2;
    exp_q.push_back(rec(2'b10, 1'b0, 1'b1, 4'd11, 4'd13, 3'd2, 8'd4, 2'b00));
    exp_q.push_back(rec(2'b01, 1'b0, 1'b1, 4'd2, 4'd3, 3'd1, 8'd8, 2'b01));
    req = 2'b11;
    wait_ack();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("midrst");
    rst = 1'b0;
    wait_ack();
    req = 2'b00;
    count_busy(n);
    check("post_rst_busy_len", 32'(n), 32'd10);

    repeat (5) @(negedge clk);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
